// File: rtl/mips_pkg.sv
// Shared types and constants for the execute-stage multiply/divide engine.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } md_state_t;

    typedef enum logic {
        MD_MULT,
        MD_DIV
    } md_op_t;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the
// quotient MSB into the remainder, subtract the divisor if it fits.
module md_div_step
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        // When fits is set the true difference is below 2^WIDTH, so the low bits suffice.
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = fits ? diff : shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide engine owning the HI/LO registers.
// Operates on magnitudes for WIDTH steps, then applies sign correction.
module multdiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult,
    input  logic             div,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    md_state_t          state;
    md_state_t          state_next;
    md_op_t             op;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               a_neg;
    logic               b_neg;

    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    md_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (acc[2*WIDTH-1:WIDTH]),
        .quo_in  (acc[WIDTH-1:0]),
        .divisor (opnd),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    always_comb begin
        a_mag_in   = rs_data[WIDTH-1] ? -rs_data : rs_data;
        b_mag_in   = rt_data[WIDTH-1] ? -rt_data : rt_data;
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        prod_fixed = (a_neg ^ b_neg) ? -acc : acc;
        quo_fixed  = (a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fixed  = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (mult)     state_next = MUL;
                else if (div) state_next = DIV;
            end
            MUL, DIV: begin
                if (count == CW'(1)) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op          <= MD_MULT;
            count       <= '0;
            acc         <= '0;
            opnd        <= '0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state       <= state_next;
            busy        <= (state_next != IDLE);
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mult || div) begin
                        a_neg <= rs_data[WIDTH-1];
                        b_neg <= rt_data[WIDTH-1];
                        count <= CW'(WIDTH);
                        // acc low half holds the multiplier or the dividend; opnd the other operand.
                        if (mult) begin
                            op   <= MD_MULT;
                            acc  <= (2*WIDTH)'(b_mag_in);
                            opnd <= a_mag_in;
                        end else begin
                            op   <= MD_DIV;
                            acc  <= (2*WIDTH)'(a_mag_in);
                            opnd <= b_mag_in;
                        end
                    end
                end
                MUL: begin
                    acc   <= {mul_sum, acc[WIDTH-1:1]};
                    count <= count - CW'(1);
                end
                DIV: begin
                    acc   <= {rem_next, quo_next};
                    count <= count - CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (op == MD_MULT) begin
                        {hi, lo} <= prod_fixed;
                    end else if (opnd == '0) begin
                        // A zero divisor shifts the whole dividend magnitude into the remainder.
                        hi          <= a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem_fixed;
                        lo <= quo_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
